// File: rtl/fdvit_ds_pkg.sv
// Shared types and size helpers for the downsampler token collector.
package fdvit_ds_pkg;

  typedef enum logic {COLLECT, DRAIN} ds_coll_state_t;
  typedef logic [7:0] pix_t;

  localparam int CIN_DEF  = 64;
  localparam int HOUT_DEF = 19;

  function automatic int ntok(input int hout);
    return hout * hout;
  endfunction

  function automatic int ch_w(input int cin);
    return $clog2(cin);
  endfunction

  function automatic int tok_w(input int hout);
    return $clog2(hout * hout);
  endfunction

  localparam int NTOK  = ntok(HOUT_DEF);
  localparam int CH_W  = ch_w(CIN_DEF);
  localparam int TOK_W = tok_w(HOUT_DEF);

endpackage

// File: rtl/ds_slice_buffer.sv
// Channel-complete slice store: whole-slice write per channel, one (row,col) across all channels read.
// Read is combinational from registered storage; no flow control of its own.
module ds_slice_buffer
  import fdvit_ds_pkg::*;
#(
  parameter int CIN  = CIN_DEF,
  parameter int HOUT = HOUT_DEF,
  localparam int CHW = ch_w(CIN),
  localparam int RCW = $clog2(HOUT)
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [CHW-1:0]                wr_ch,
  input  pix_t [HOUT-1:0][HOUT-1:0]     wr_slice,
  input  logic [RCW-1:0]                rd_row,
  input  logic [RCW-1:0]                rd_col,
  output pix_t [CIN-1:0]                rd_tok
);

  pix_t [HOUT-1:0][HOUT-1:0] mem [CIN];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ch] <= wr_slice;
  end

  always_comb begin
    rd_tok = '0;
    for (int ch = 0; ch < CIN; ch++) begin
      rd_tok[ch] = mem[ch][rd_row][rd_col];
    end
  end

endmodule

// File: rtl/ds_token_collector.sv
// Collects CIN slices, then streams HOUT*HOUT channel tokens; first token 1 cycle after last slice,
// tokens hold under tok_ready=0, slices during drain are dropped (flagged if DS_TOKEN_OVERFLOW_CHK_EN).
module ds_token_collector
  import fdvit_ds_pkg::*;
#(
  parameter int CIN  = CIN_DEF,
  parameter int HOUT = HOUT_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  pix_t [HOUT-1:0][HOUT-1:0]     slice_in,
  input  logic                          slice_valid,
  output logic                          collect_ready,
  output pix_t [CIN-1:0]                tok_data,
  output logic                          tok_valid,
  input  logic                          tok_ready,
  output logic                          tok_last,
  output logic                          frame_done,
  output logic                          overflow_err
);

  localparam int NT  = ntok(HOUT);
  localparam int CHW = ch_w(CIN);
  localparam int TKW = tok_w(HOUT);
  localparam int RCW = $clog2(HOUT);

  if (CIN < 2 || HOUT < 2) begin : g_bad_params
    $error("ds_token_collector: CIN and HOUT must both be at least 2");
  end

  ds_coll_state_t state, state_nxt;
  logic [CHW-1:0] ch_cnt, ch_nxt;
  logic [TKW-1:0] tok_idx, idx_nxt;
  logic           wr_en;
  logic [RCW-1:0] rd_row, rd_col;
  pix_t [CIN-1:0] rd_tok;

  assign rd_row   = RCW'(tok_idx / TKW'(HOUT));
  assign rd_col   = RCW'(tok_idx % TKW'(HOUT));
  assign tok_last = (state == DRAIN) && (tok_idx == TKW'(NT - 1));
  assign tok_data = tok_valid ? rd_tok : '0;

  ds_slice_buffer #(.CIN(CIN), .HOUT(HOUT)) u_buf (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_ch    (ch_cnt),
    .wr_slice (slice_in),
    .rd_row   (rd_row),
    .rd_col   (rd_col),
    .rd_tok   (rd_tok)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= COLLECT;
      ch_cnt  <= '0;
      tok_idx <= '0;
    end else begin
      state   <= state_nxt;
      ch_cnt  <= ch_nxt;
      tok_idx <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ch_nxt        = ch_cnt;
    idx_nxt       = tok_idx;
    collect_ready = 1'b0;
    tok_valid     = 1'b0;
    wr_en         = 1'b0;
    frame_done    = 1'b0;
    case (state)
      COLLECT: begin
        collect_ready = 1'b1;
        if (slice_valid) begin
          wr_en = 1'b1;
          if (ch_cnt == CHW'(CIN - 1)) begin
            ch_nxt    = '0;
            state_nxt = DRAIN;
          end else begin
            ch_nxt = ch_cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        tok_valid = 1'b1;
        if (tok_ready) begin
          if (tok_last) begin
            idx_nxt    = '0;
            frame_done = 1'b1;
            state_nxt  = COLLECT;
          end else begin
            idx_nxt = tok_idx + 1'b1;
          end
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

`ifdef DS_TOKEN_OVERFLOW_CHK_EN
  // Sticky: any slice offered while draining was lost upstream.
  always_ff @(posedge clk) begin
    if (!rst_n)                              overflow_err <= 1'b0;
    else if (state == DRAIN && slice_valid)  overflow_err <= 1'b1;
  end
`else
  assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_ds_token_collector.sv
// Directed bench: small (CIN=4, HOUT=3) instance for frame/backpressure/overflow/reset cases,
// default instance for back-to-back full-size frames.
module tb_ds_token_collector;
  import fdvit_ds_pkg::*;

`ifdef DS_TOKEN_OVERFLOW_CHK_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic                  s_rst_n, s_sv, s_cr, s_tv, s_tr, s_tl, s_fd, s_ov;
  pix_t [2:0][2:0]       s_slice;
  pix_t [3:0]            s_tok;

  logic                  d_rst_n, d_sv, d_cr, d_tv, d_tr, d_tl, d_fd, d_ov;
  pix_t [18:0][18:0]     d_slice;
  pix_t [63:0]           d_tok;

  ds_token_collector #(.CIN(4), .HOUT(3)) dut_s (
    .clk(clk), .rst_n(s_rst_n), .slice_in(s_slice), .slice_valid(s_sv),
    .collect_ready(s_cr), .tok_data(s_tok), .tok_valid(s_tv), .tok_ready(s_tr),
    .tok_last(s_tl), .frame_done(s_fd), .overflow_err(s_ov)
  );

  ds_token_collector dut_d (
    .clk(clk), .rst_n(d_rst_n), .slice_in(d_slice), .slice_valid(d_sv),
    .collect_ready(d_cr), .tok_data(d_tok), .tok_valid(d_tv), .tok_ready(d_tr),
    .tok_last(d_tl), .frame_done(d_fd), .overflow_err(d_ov)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_s(input int t);
    logic [31:0] v;
    for (int ch = 0; ch < 4; ch++) v[ch*8 +: 8] = 8'(16 * ch + t);
    return v;
  endfunction

  function automatic pix_t pf(input int frame, input int ch, input int r, input int c);
    if (frame == 1) return 8'(ch + 3 * r + 5 * c);
    return 8'(7 * ch + r + 11 * c + 1);
  endfunction

  task automatic set_s(input int ch, input bit ff);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        s_slice[r][c] = ff ? 8'hFF : 8'(16 * ch + 3 * r + c);
  endtask

  task automatic load_s(input int gap);
    for (int ch = 0; ch < 4; ch++) begin
      set_s(ch, 1'b0);
      s_sv = 1'b1;
      chk("load_ready", s_cr, 1'b1);
      tick();
      if (ch < 3) chk("no_early_drain", s_tv, 1'b0);
      if (ch == 1 && gap > 0) begin
        s_sv = 1'b0;
        repeat (gap) begin
          tick();
          chk("gap_no_drain", s_tv, 1'b0);
        end
      end
    end
    s_sv = 1'b0;
    #1;
    chk("first_tok_latency", s_tv, 1'b1);
  endtask

  // mode 0: always ready, 1: ready 1,0,0 pattern, 2: 0xFF slices offered mid-drain, 3: reset at token 5
  task automatic drain_s(input int mode);
    int  e   = 0;
    int  cyc = 0;
    logic tr;
    while (e < 9 && cyc < 100) begin
      tr   = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
      s_tr = tr;
      s_sv = 1'b0;
      if (mode == 2 && (e == 2 || e == 8)) begin
        set_s(0, 1'b1);
        s_sv = 1'b1;
      end
      if (mode == 3 && e == 5) begin
        s_rst_n = 1'b0;
        tick();
        s_rst_n = 1'b1;
        s_tr    = 1'b0;
        #1;
        chk("rst_collect_ready", s_cr, 1'b1);
        chk("rst_tok_valid", s_tv, 1'b0);
        chk("rst_frame_done", s_fd, 1'b0);
        chk("rst_overflow", s_ov, 1'b0);
        return;
      end
      #1;
      chk("drain_valid", s_tv, 1'b1);
      chk("drain_not_ready", s_cr, 1'b0);
      chk("tok_data", s_tok, exp_s(e));
      if (e == 4) chk("tok4", s_tok, 32'h34241404);
      chk("tok_last", s_tl, (e == 8));
      chk("frame_done", s_fd, (tr && e == 8));
      tick();
      cyc++;
      if (tr) e++;
    end
    s_sv = 1'b0;
    s_tr = 1'b0;
    #1;
    chk("drain_complete", e, 9);
    chk("post_ready", s_cr, 1'b1);
    chk("post_valid", s_tv, 1'b0);
    chk("post_done", s_fd, 1'b0);
  endtask

  task automatic load_d(input int frame);
    for (int ch = 0; ch < 64; ch++) begin
      for (int r = 0; r < 19; r++)
        for (int c = 0; c < 19; c++)
          d_slice[r][c] = pf(frame, ch, r, c);
      d_sv = 1'b1;
      tick();
      if (ch == 62) chk("d_no_early_drain", d_tv, 1'b0);
    end
    d_sv = 1'b0;
    #1;
    chk("d_first_tok_latency", d_tv, 1'b1);
  endtask

  task automatic drain_d(input int frame);
    logic [511:0] exp;
    d_tr = 1'b1;
    for (int t = 0; t < 361; t++) begin
      exp = '0;
      for (int ch = 0; ch < 64; ch++) exp[ch*8 +: 8] = pf(frame, ch, t / 19, t % 19);
      chk("d_valid", d_tv, 1'b1);
      chk("d_tok_data", d_tok, exp);
      chk("d_tok_last", d_tl, (t == 360));
      chk("d_frame_done", d_fd, (t == 360));
      tick();
    end
    chk("d_post_ready", d_cr, 1'b1);
    chk("d_post_valid", d_tv, 1'b0);
  endtask

  initial begin
    s_rst_n = 1'b0; s_sv = 1'b0; s_tr = 1'b0; s_slice = '0;
    d_rst_n = 1'b0; d_sv = 1'b0; d_tr = 1'b0; d_slice = '0;
    repeat (2) tick();
    s_rst_n = 1'b1;
    d_rst_n = 1'b1;
    #1;
    chk("reset_ready", s_cr, 1'b1);
    chk("reset_valid", s_tv, 1'b0);
    chk("reset_last", s_tl, 1'b0);
    chk("reset_done", s_fd, 1'b0);
    chk("reset_overflow", s_ov, 1'b0);
    chk("reset_data", s_tok, 32'h0);
    chk("d_reset_ready", d_cr, 1'b1);
    chk("d_reset_valid", d_tv, 1'b0);
    chk("d_reset_data", d_tok, '0);

    load_s(0); drain_s(0);
    load_s(0); drain_s(1);
    load_s(2); drain_s(0);
    load_s(0); drain_s(2);
    chk("overflow_set", s_ov, OVF_EXP);
    load_s(0); drain_s(0);
    chk("overflow_sticky", s_ov, OVF_EXP);
    load_s(0); drain_s(3);
    load_s(0); drain_s(0);

    load_d(1); drain_d(1);
    load_d(2); drain_d(2);
    chk("d_overflow", d_ov, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
